// File: rtl/jtag_gpr_access_if.sv
// Debug-module request/response channel into the GPR access sequencer.
// master = debug module side, slave = jtag_gpr_access.
// Both channels use valid/ready; a transfer happens when both are high at posedge clk.
interface jtag_gpr_access_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [4:0]  req_addr_i;
  logic [31:0] req_wdata_i;
  logic        resp_valid_o;
  logic        resp_ready_i;
  logic [31:0] resp_rdata_o;
  logic        resp_err_o;

  modport master (
    output req_valid_i, req_we_i, req_addr_i, req_wdata_i, resp_ready_i,
    input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o
  );

  modport slave (
    input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, resp_ready_i,
    output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o
  );
endinterface

// File: rtl/jtag_gpr_access.sv
// Sequences one debug GPR read/write into the register-file debug port, retrying writes lost to the core.
// Latency accept->resp_valid: read 2, write 2 + lost attempts (+1 with readback), x0 write 1 cycle.
// One transaction in flight; req_ready low until the response handshake; response held until resp_ready.
// Optional JTAG_GPR_READBACK_EN: committed writes re-read the register and return that value.
module jtag_gpr_access #(
  parameter int unsigned MAX_RETRY = 15,
  parameter int unsigned CNT_W     = 4
) (
  input  logic              clk,
  input  logic              rst,
  jtag_gpr_access_if.slave  dbg,
  input  logic              ex_we_i,
  input  logic [4:0]        ex_waddr_i,
  input  logic [31:0]       ex_wdata_i,
  output logic              jtag_we_o,
  output logic [4:0]        jtag_addr_o,
  output logic [31:0]       jtag_data_o,
  input  logic [31:0]       jtag_data_i
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [4:0]       addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             req_ready_q, req_ready_d;
  logic             resp_valid_q, resp_valid_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_q, err_d;
  logic             jwe_q, jwe_d;
  logic [4:0]       jaddr_q, jaddr_d;
  logic [31:0]      jdata_q, jdata_d;
  logic             lost;
  logic [31:0]      read_val;

  // Core writes win the register-file write port unless they target x0.
  assign lost    = ex_we_i && (ex_waddr_i != 5'd0);
  assign cnt_inc = cnt_q + 1'b1;

  // Read value with same-cycle core write forwarded; x0 always reads zero.
  always_comb begin
    read_val = jtag_data_i;
    if (addr_q == 5'd0)
      read_val = 32'd0;
    else if (ex_we_i && (ex_waddr_i == addr_q))
      read_val = ex_wdata_i;
  end

  // Next-state and next-output logic; every output is registered from here.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    jwe_d        = jwe_q;
    jaddr_d      = jaddr_q;
    jdata_d      = jdata_q;
    case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (dbg.req_valid_i) begin
          addr_d      = dbg.req_addr_i;
          wdata_d     = dbg.req_wdata_i;
          cnt_d       = '0;
          req_ready_d = 1'b0;
          if (!dbg.req_we_i) begin
            state_d = READ;
            jaddr_d = dbg.req_addr_i;
          end else if (dbg.req_addr_i != 5'd0) begin
            state_d = WRITE;
            jwe_d   = 1'b1;
            jaddr_d = dbg.req_addr_i;
            jdata_d = dbg.req_wdata_i;
          end else begin
            // x0 is hardwired: answer immediately without touching the port.
            state_d      = RESP;
            resp_valid_d = 1'b1;
            rdata_d      = 32'd0;
            err_d        = 1'b0;
          end
        end
      end
      WRITE: begin
        if (!lost) begin
          jwe_d = 1'b0;
`ifdef JTAG_GPR_READBACK_EN
          state_d = READ;
`else
          state_d      = RESP;
          resp_valid_d = 1'b1;
          rdata_d      = wdata_q;
          err_d        = 1'b0;
`endif
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_W'(MAX_RETRY)) begin
            state_d      = RESP;
            jwe_d        = 1'b0;
            resp_valid_d = 1'b1;
            rdata_d      = 32'd0;
            err_d        = 1'b1;
          end
        end
      end
      READ: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        rdata_d      = read_val;
        err_d        = 1'b0;
      end
      RESP: begin
        if (dbg.resp_ready_i) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any transaction and drops jtag_we_o.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      addr_q       <= 5'd0;
      wdata_q      <= 32'd0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      rdata_q      <= 32'd0;
      err_q        <= 1'b0;
      jwe_q        <= 1'b0;
      jaddr_q      <= 5'd0;
      jdata_q      <= 32'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      jwe_q        <= jwe_d;
      jaddr_q      <= jaddr_d;
      jdata_q      <= jdata_d;
    end
  end

  assign dbg.req_ready_o  = req_ready_q;
  assign dbg.resp_valid_o = resp_valid_q;
  assign dbg.resp_rdata_o = rdata_q;
  assign dbg.resp_err_o   = err_q;
  assign jtag_we_o        = jwe_q;
  assign jtag_addr_o      = jaddr_q;
  assign jtag_data_o      = jdata_q;

endmodule

// File: doc/jtag_gpr_access.md
Name: jtag_gpr_access

Overview:
- Sequencer between the debug-module request channel and the register file's debug port (jtag_we/jtag_addr/jtag_data).
- Takes one GPR read or write per valid/ready transaction and drives the register-file debug port.
- Retries writes that lose to a same-cycle core (ex) write, because the core write always has priority.
- Returns read data via a valid/ready response channel, forwarding any same-cycle core write to the read address.

Parameters:
- MAX_RETRY, 15: write attempts lost to the core before giving up with an error. Legal range 1..2^CNT_W-1.
- CNT_W, 4: width of the retry counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when high with req_valid_i
- req_we_i  in  1  1=write, 0=read
- req_addr_i  in  5  GPR index
- req_wdata_i  in  32  write data
- resp_valid_o  out  1  response valid
- resp_ready_i  in  1  response consumed
- resp_rdata_o  out  32  read data (write: data committed)
- resp_err_o  out  1  write abandoned after MAX_RETRY
- ex_we_i  in  1  core write enable (observed)
- ex_waddr_i  in  5  core write address
- ex_wdata_i  in  32  core write data
- jtag_we_o  out  1  to register file debug write enable
- jtag_addr_o  out  5  to register file debug address
- jtag_data_o  out  32  to register file debug write data
- jtag_data_i  in  32  from register file debug read data (combinational, no bypass)

Behaviour:
- Reset values (rst=1 at posedge): state IDLE, req_ready_o=1, resp_valid_o=0, resp_rdata_o=0, resp_err_o=0, jtag_we_o=0, jtag_addr_o=0, jtag_data_o=0, retry counter=0.
- All outputs are registered.
- Reset mid-transaction aborts it with no response; a pending jtag_we_o drops in the same cycle.
- States: IDLE, WRITE, READ, RESP.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i: latch addr/we/wdata, clear counter, set req_ready_o=0.
  - Write to addr!=0 -> WRITE. jtag_we_o=1, addr and data are driven from the next cycle.
  - Write to addr 0 -> RESP directly with rdata=0, err=0. No port activity.
  - Read -> READ. jtag_addr_o=addr.
- WRITE, one attempt per cycle with jtag_we_o=1:
  - Attempt commits iff !(ex_we_i && ex_waddr_i!=0).
  - Commit -> RESP, jtag_we_o=0, rdata=wdata, err=0.
  - Lost attempt -> counter+1. If counter+1==MAX_RETRY -> RESP, jtag_we_o=0, err=1, rdata=0. Otherwise stay in WRITE.
- READ, one cycle:
  - addr==0 -> capture 0.
  - Else if ex_we_i && ex_waddr_i==addr -> capture ex_wdata_i (forwarding).
  - Else capture jtag_data_i.
  - -> RESP, err=0.
- RESP:
  - resp_valid_o=1, rdata/err stable until resp_ready_i is sampled high.
  - Then -> IDLE, resp_valid_o=0, req_ready_o=1.
  - The next request cannot be accepted in the handshake cycle.
- Latency, request accept edge to resp_valid_o high:
  - Read: 2 cycles.
  - Write: 2 cycles plus 1 per lost attempt.
  - x0 write: 1 cycle.
- Throughput: at most one outstanding transaction.
- jtag_addr_o holds its last value while idle.
- jtag_we_o is never high outside WRITE.

Optional Feature:
- JTAG_GPR_READBACK_EN defined:
  - After a committed write, go WRITE->READ instead of WRITE->RESP.
  - Response returns the value read back in READ, with the normal forwarding rule. A core write landing in that cycle is reported.
  - Write latency is +1 cycle.
  - err=1 path is unchanged (no readback).
- Macro undefined: rdata for a committed write = latched wdata; READ is entered only for read requests.

Test Plan:
- Reset with all request inputs high -> after rst deasserts: req_ready_o=1, resp_valid_o=0, jtag_we_o=0, jtag_addr_o=0.
- Write x5=0xDEADBEEF, ex_we_i=0 -> jtag_we_o=1 for exactly 1 cycle with addr=5, data=0xDEADBEEF. resp_valid_o 2 cycles after accept, rdata=0xDEADBEEF, err=0.
- Write x7=0x1234 with ex_we_i=1, ex_waddr_i=3 for 3 cycles -> jtag_we_o high 4 cycles, commits on the 4th, err=0.
- Write x7 with ex_we_i=1, ex_waddr_i=9 continuously -> after 15 attempts: resp_valid_o=1, err=1, jtag_we_o=0.
- Read x10 (jtag_data_i=0xAAAA5555) while in the READ cycle ex_we_i=1, ex_waddr_i=10, ex_wdata_i=0x0F0F0F0F -> rdata=0x0F0F0F0F. Repeat with ex_waddr_i=11 -> rdata=0xAAAA5555.
- Read x0 and write x0=0xFFFFFFFF -> both return rdata=0, err=0. No jtag_we_o pulse. Hold resp_ready_i=0 for 5 cycles -> resp_valid_o and data stay stable, req_ready_o=0.
